// File: rtl/visitor_direction_detector.sv
// Door-crossing direction decoder: synchronizes and debounces two beam sensors, then
// sequences them into enter/exit events and a saturating occupancy count.
// Optional DIRECTION_TIMEOUT_EN aborts a crossing that stalls for TIMEOUT_CYCLES.
module visitor_direction_detector #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8,
   parameter int MAX_COUNT       = 99,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sens_a,
   input  logic             sens_b,
   output logic             enter_pulse,
   output logic             exit_pulse,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             seq_error
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COUNT);

   typedef enum logic [2:0] {
      IDLE, A1, A2, A3, B1, B2, B3, WAIT_CLR
   } state_t;

   // Index 1 is sensor A, index 0 is sensor B, so pair reads as {a_d, b_d}.
   logic [1:0]      raw;
   logic [1:0]      sync1, sync2;
   logic [1:0]      pair;
   logic [DB_W-1:0] db_cnt [2];

   assign raw = {sens_a, sens_b};

   // NOTE: all clocked state uses non-blocking assignments so every flop samples
   // pre-edge values, which is what makes the two-stage synchronizer two stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_debounce
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt[i] <= '0;
            pair[i]   <= 1'b0;
         end else if (sync2[i] == pair[i]) begin
            db_cnt[i] <= '0;
         end else if (db_cnt[i] == DB_LAST) begin
            db_cnt[i] <= '0;
            pair[i]   <= sync2[i];
         end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end

   state_t state, state_nxt;
   logic   enter_nxt, exit_nxt, err_nxt;
   logic   timeout;
   logic   in_seq;

   assign in_seq = (state != IDLE) && (state != WAIT_CLR);

`ifdef DIRECTION_TIMEOUT_EN
   localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES);
   logic [TM_W-1:0] timer;

   // Restarts on every state change, so only a stalled crossing can expire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                timer <= '0;
      else if (!in_seq || (state_nxt != state)) timer <= '0;
      else if (timer != TM_LAST)                timer <= timer + 1'b1;
   end

   assign timeout = in_seq && (timer == TM_LAST);
`else
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   // NOTE: every combinational output gets a default first, so no path can
   // infer a latch.
   always_comb begin
      state_nxt = state;
      enter_nxt = 1'b0;
      exit_nxt  = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            unique case (pair)
               2'b10: state_nxt = A1;
               2'b01: state_nxt = B1;
               2'b11: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: ;
            endcase
         end
         A1: begin
            unique case (pair)
               2'b11: state_nxt = A2;
               2'b00: state_nxt = IDLE;
               2'b01: state_nxt = A3;
               default: ;
            endcase
         end
         A2: begin
            unique case (pair)
               2'b01: state_nxt = A3;
               2'b10: state_nxt = A1;
               2'b00: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: ;
            endcase
         end
         A3: begin
            unique case (pair)
               2'b00: begin state_nxt = IDLE; enter_nxt = 1'b1; end
               2'b11: state_nxt = A2;
               2'b10: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: ;
            endcase
         end
         B1: begin
            unique case (pair)
               2'b11: state_nxt = B2;
               2'b00: state_nxt = IDLE;
               2'b10: state_nxt = B3;
               default: ;
            endcase
         end
         B2: begin
            unique case (pair)
               2'b10: state_nxt = B3;
               2'b01: state_nxt = B1;
               2'b00: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: ;
            endcase
         end
         B3: begin
            unique case (pair)
               2'b00: begin state_nxt = IDLE; exit_nxt = 1'b1; end
               2'b11: state_nxt = B2;
               2'b01: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: ;
            endcase
         end
         WAIT_CLR: begin
            if (pair == 2'b00) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (timeout) begin
         state_nxt = WAIT_CLR;
         enter_nxt = 1'b0;
         exit_nxt  = 1'b0;
         err_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   logic [CNT_W-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (enter_nxt && (count != MAX_C))   count_nxt = count + 1'b1;
      else if (exit_nxt && (count != '0))  count_nxt = count - 1'b1;
   end

   // Flags are registered from the next count so they move on the same edge as count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         enter_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         count       <= count_nxt;
         full        <= (count_nxt == MAX_C);
         empty       <= (count_nxt == '0);
         enter_pulse <= enter_nxt;
         exit_pulse  <= exit_nxt;
         seq_error   <= err_nxt;
      end
   end

endmodule
